// File: rtl/encoder_pkg.sv
// Shared types and constants for the configurable extended-Hamming (SEC-DED) encoder.
// Mode encodings, per-mode codeword/data widths and small constant helpers.
package encoder_pkg;

    typedef enum logic [1:0] {
        CW8        = 2'b00,
        CW16       = 2'b01,
        CW32       = 2'b10,
        CW_ILLEGAL = 2'b11
    } cw_mode_e;

    localparam int BUS_W            = 33;
    localparam int ILLEGAL_FLAG_BIT = 32;

    // Codeword width n and payload width k for CW8, CW16 and CW32, in that order.
    localparam int CW_N [3] = '{8, 16, 32};
    localparam int CW_K [3] = '{4, 11, 26};

    // True for the Hamming positions that carry a parity bit.
    function automatic logic is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

    // Even parity over a full bus; used where the whole vector is significant.
    function automatic logic even_parity(input logic [BUS_W-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/encoder_hamming_enc_core.sv
// Combinational extended-Hamming encoder with R parity bits.
// Produces a 2**R-bit codeword: positions 1..2**R-1 in bits [N-2:0], overall parity in bit N-1.
module hamming_enc_core
    import encoder_pkg::*;
#(
    parameter  int R = 3,
    localparam int N = 2 ** R,
    localparam int K = N - R - 1
) (
    input  logic [K-1:0] data,
    output logic [N-1:0] cw
);

    // Data positions that a given parity bit j covers (index has bit j set).
    function automatic logic [N-1:1] cover_mask(input int j);
        logic [N-1:1] m;
        m = {(N - 1){1'b0}};
        for (int p = 1; p < N; p++) begin
            if ((((p >> j) & 1) == 1) && !is_pow2(p)) begin
                m[p] = 1'b1;
            end else begin
                m[p] = 1'b0;
            end
        end
        return m;
    endfunction

    logic [N-1:1] data_pos_s;
    logic [N-1:1] pos_s;

    // Position p's data index is p minus the parity slots at or below it, minus one.
    for (genvar p = 1; p < N; p++) begin : g_pos
        if (is_pow2(p)) begin : g_par
            assign data_pos_s[p] = 1'b0;
            assign pos_s[p]      = ^(data_pos_s & cover_mask($clog2(p)));
        end else begin : g_dat
            assign data_pos_s[p] = data[p - $clog2(p + 1) - 1];
            assign pos_s[p]      = data_pos_s[p];
        end
    end

    assign cw = {^pos_s, pos_s};

endmodule

// File: rtl/encoder.sv
// Mode-selectable SEC-DED encoder: three fixed-size cores, a mode mux and one output register.
// Mode 11 yields only the illegal-mode flag in bit 32.
module encoder
    import encoder_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       CODEWORD_WIDTH,
    input  logic [BUS_W-1:0] data_in,
    output logic [BUS_W-1:0] data_out
);

    cw_mode_e                mode_s;
    logic [CW_N[0]-1:0]      cw8_s;
    logic [CW_N[1]-1:0]      cw16_s;
    logic [CW_N[2]-1:0]      cw32_s;
    logic [BUS_W-1:0]        next_s;
    logic                    unused_upper_s;

    assign mode_s = cw_mode_e'(CODEWORD_WIDTH);

    // Payload bits above the widest data field never reach a codeword.
    assign unused_upper_s = ^data_in[BUS_W-1:CW_K[2]];

    hamming_enc_core #(.R(3)) u_cw8 (
        .data (data_in[CW_K[0]-1:0]),
        .cw   (cw8_s)
    );

    hamming_enc_core #(.R(4)) u_cw16 (
        .data (data_in[CW_K[1]-1:0]),
        .cw   (cw16_s)
    );

    hamming_enc_core #(.R(5)) u_cw32 (
        .data (data_in[CW_K[2]-1:0]),
        .cw   (cw32_s)
    );

    // Select the active codeword and zero-fill the bus above it.
    always_comb begin
        next_s = {BUS_W{1'b0}};
        case (mode_s)
            CW8:        next_s[CW_N[0]-1:0]       = cw8_s;
            CW16:       next_s[CW_N[1]-1:0]       = cw16_s;
            CW32:       next_s[CW_N[2]-1:0]       = cw32_s;
            CW_ILLEGAL: next_s[ILLEGAL_FLAG_BIT]  = 1'b1;
            default:    next_s                    = {BUS_W{1'b0}};
        endcase
    end

    // Output register; reset drops whatever word was in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out <= {BUS_W{1'b0}};
        end else begin
            data_out <= next_s;
        end
    end

endmodule

// File: tb/tb_encoder.sv
// Self-checking bench for encoder: directed vectors, then a random sweep against a
// positional Hamming model plus single-bit-flip syndrome checks on each produced codeword.
module tb_encoder;

    logic        clk;
    logic        rst;
    logic [1:0]  CODEWORD_WIDTH;
    logic [32:0] data_in;
    logic [32:0] data_out;

    int total;
    int bad;

    encoder dut (
        .clk            (clk),
        .rst            (rst),
        .CODEWORD_WIDTH (CODEWORD_WIDTH),
        .data_in        (data_in),
        .data_out       (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: place data into non-power-of-two positions, then fill parity and P.
    function automatic logic [32:0] model(input logic [1:0] mode, input logic [32:0] d);
        logic [32:0] res;
        logic        pos [32];
        int          n;
        int          m;
        int          di;
        logic        par;
        res = 33'h0;
        if (mode == 2'b11) return 33'h1_0000_0000;
        m  = 3 + int'(mode);
        n  = 1 << m;
        di = 0;
        for (int p = 0; p < 32; p++) pos[p] = 1'b0;
        for (int p = 1; p < n; p++) begin
            if ((p & (p - 1)) != 0) begin
                pos[p] = d[di];
                di++;
            end
        end
        for (int j = 0; j < m; j++) begin
            par = 1'b0;
            for (int p = 1; p < n; p++) if (((p >> j) & 1) == 1) par ^= pos[p];
            pos[1 << j] = par;
        end
        par = 1'b0;
        for (int p = 1; p < n; p++) begin
            res[p - 1] = pos[p];
            par ^= pos[p];
        end
        res[n - 1] = par;
        return res;
    endfunction

    function automatic int syndrome(input logic [32:0] w, input int n);
        int s;
        s = 0;
        for (int i = 0; i < n - 1; i++) if (w[i]) s ^= (i + 1);
        return s;
    endfunction

    function automatic logic overall(input logic [32:0] w, input int n);
        logic p;
        p = 1'b0;
        for (int i = 0; i < n; i++) p ^= w[i];
        return p;
    endfunction

    task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply one word, clock it through, sample after the edge.
    task automatic step(input logic [1:0] mode, input logic [32:0] d);
        CODEWORD_WIDTH = mode;
        data_in        = d;
        @(posedge clk);
        #1;
    endtask

    // Every single flip must disturb P; flips below P must also give the flipped position.
    task automatic flip_checks(input logic [1:0] mode, input logic [32:0] w);
        int          n;
        logic [32:0] f;
        n = 8 << int'(mode);
        for (int i = 0; i < n; i++) begin
            f = w;
            f[i] = ~f[i];
            check("flip_p", {32'h0, overall(f, n)}, 33'h1);
            if (i < n - 1) check("flip_syn", 33'(syndrome(f, n)), 33'(i + 1));
            else           check("flip_syn_p", 33'(syndrome(f, n)), 33'h0);
        end
    endtask

    initial begin
        logic [1:0]  mode;
        logic [32:0] d;
        total = 0;
        bad   = 0;

        rst = 1'b1;
        CODEWORD_WIDTH = 2'b00;
        data_in = 33'h1_FFFF_FFFF;
        @(posedge clk); #1;
        check("reset_c1", data_out, 33'h0);
        @(posedge clk); #1;
        check("reset_c2", data_out, 33'h0);
        rst = 1'b0;

        step(2'b00, 33'h0_02AA_AAAA); check("m00_a", data_out, 33'h0_0000_00D2);
        step(2'b00, 33'h0_0000_000F); check("m00_f", data_out, 33'h0_0000_00FF);
        step(2'b01, 33'h0_0000_0001); check("m01_1", data_out, 33'h0_0000_8007);
        step(2'b10, 33'h0_0000_0001); check("m10_1", data_out, 33'h0_8000_0007);
        step(2'b11, 33'h0_0000_0001); check("m11",   data_out, 33'h1_0000_0000);
        step(2'b11, 33'h1_FFFF_FFFF); check("m11_f", data_out, 33'h1_0000_0000);

        step(2'b00, 33'h0); check("zero_00", data_out, 33'h0);
        step(2'b01, 33'h0); check("zero_01", data_out, 33'h0);
        step(2'b10, 33'h0); check("zero_10", data_out, 33'h0);

        step(2'b00, 33'h1_FFFF_FFF5); check("up_hi", data_out, model(2'b00, 33'h5));
        step(2'b00, 33'h0_A5A5_A5A5); check("up_mix", data_out, model(2'b00, 33'h5));
        step(2'b00, 33'h0_0000_0005); check("up_lo", data_out, model(2'b00, 33'h5));
        step(2'b01, 33'h1_FFFF_FFFF); check("m01_ones", data_out, model(2'b01, 33'h7FF));
        step(2'b10, 33'h1_FFFF_FFFF); check("m10_ones", data_out, model(2'b10, 33'h3FF_FFFF));

        // Reset asserted with a live word: that word must never appear.
        rst = 1'b1;
        step(2'b10, 33'h0_0000_0001); check("rst_mid", data_out, 33'h0);
        rst = 1'b0;
        step(2'b10, 33'h0_0000_0001); check("post_rst", data_out, 33'h0_8000_0007);

        for (int it = 0; it < 200; it++) begin
            mode = 2'($urandom_range(0, 2));
            d    = {1'($urandom), 32'($urandom)};
            step(mode, d);
            check("rand", data_out, model(mode, d));
            total++;
            assert (syndrome(data_out, 8 << int'(mode)) == 0 && overall(data_out, 8 << int'(mode)) == 1'b0) else begin
                bad++;
                $error("FAIL rand_clean observed=%h expected=zero_syndrome", data_out);
            end
            if (it < 20) flip_checks(mode, data_out);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
